// File: rtl/circuit_01.sv
// circuit_01: table-driven 3-input function with registered copy, rise pulse and input statistics
module circuit_01 #(
    parameter logic [7:0] TRUTH_TABLE = 8'b1110_1000,
    parameter int         CNT_W       = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             a,
    input  logic             b,
    input  logic             c,
    output logic             d,
    input  logic             clr,
    output logic             d_q,
    output logic             d_rise,
    output logic [7:0]       minterm_seen,
    output logic             all_seen,
    output logic [CNT_W-1:0] ones_cnt
);
    logic [2:0] idx;
    assign idx      = {a, b, c};
    assign d        = TRUTH_TABLE[idx];
    assign all_seen = &minterm_seen;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            d_q          <= 1'b0;
            d_rise       <= 1'b0;
            minterm_seen <= '0;
            ones_cnt     <= '0;
        end else begin
            d_q          <= d;
            d_rise       <= d & ~d_q;
            minterm_seen <= clr ? '0 : minterm_seen | (8'd1 << idx);
            ones_cnt     <= clr ? '0 : (d_q && ones_cnt != '1) ? ones_cnt + 1'b1 : ones_cnt;
        end
    end
endmodule

// File: tb/tb_circuit_01.sv
// tb_circuit_01: directed stimulus with a behavioural model checked every cycle plus literal expectations
module tb_circuit_01;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       a = 1'b0, b = 1'b0, c = 1'b0, clr = 1'b0;
    logic       d, d_q, d_rise, all_seen;
    logic [7:0] minterm_seen;
    logic [7:0] ones_cnt;
    int         n_chk = 0;
    int         n_pass = 0;
    bit         chk_en = 1'b0;

    circuit_01 dut (
        .clk(clk), .rst_n(rst_n), .a(a), .b(b), .c(c), .d(d), .clr(clr),
        .d_q(d_q), .d_rise(d_rise), .minterm_seen(minterm_seen),
        .all_seen(all_seen), .ones_cnt(ones_cnt)
    );

    always #5 clk = ~clk;

    function automatic bit maj(input logic x, input logic y, input logic z);
        return (int'(x) + int'(y) + int'(z)) >= 2;
    endfunction

    bit m_dq = 0, m_rise = 0;
    bit m_seen [8] = '{default: 1'b0};
    int m_cnt = 0;

    function automatic logic [7:0] seen_vec();
        logic [7:0] v;
        for (int i = 0; i < 8; i++) v[i] = m_seen[i];
        return v;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_dq = 0; m_rise = 0; m_cnt = 0;
            for (int i = 0; i < 8; i++) m_seen[i] = 0;
        end else begin
            m_cnt  = clr ? 0 : ((m_cnt + int'(m_dq)) > 255 ? 255 : m_cnt + int'(m_dq));
            if (clr) for (int i = 0; i < 8; i++) m_seen[i] = 0;
            else m_seen[4 * int'(a) + 2 * int'(b) + int'(c)] = 1;
            m_rise = maj(a, b, c) && !m_dq;
            m_dq   = maj(a, b, c);
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            chk("model_d", 32'(d), 32'(maj(a, b, c)));
            chk("model_d_q", 32'(d_q), 32'(m_dq));
            chk("model_d_rise", 32'(d_rise), 32'(m_rise));
            chk("model_seen", 32'(minterm_seen), 32'(seen_vec()));
            chk("model_all_seen", 32'(all_seen), 32'(&seen_vec()));
            chk("model_cnt", 32'(ones_cnt), 32'(m_cnt));
        end
    end

    task automatic apply(input logic [2:0] v, input logic cl);
        {a, b, c} = v;
        clr = cl;
        @(posedge clk);
        #2;
    endtask

    task automatic release_rst();
        @(posedge clk);
        #2 rst_n = 1'b1;
    endtask

    logic [7:0] exp_d;
    initial begin
        exp_d = 8'b1110_1000;
        #1 chk_en = 1'b1;
        chk("reset_d_q", 32'(d_q), 32'd0);
        chk("reset_cnt", 32'(ones_cnt), 32'd0);
        for (int i = 0; i < 8; i++) begin
            {a, b, c} = 3'(i);
            #1 chk($sformatf("sweep_d_%0d", i), 32'(d), 32'(exp_d[i]));
            #9;
        end
        release_rst();
        for (int i = 0; i < 8; i++) apply(3'(i), 1'b0);
        chk("sweep_seen", 32'(minterm_seen), 32'hFF);
        chk("sweep_all_seen", 32'(all_seen), 32'd1);
        chk("sweep_cnt_8", 32'(ones_cnt), 32'd3);
        apply(3'b000, 1'b0);
        chk("sweep_cnt_9", 32'(ones_cnt), 32'd4);

        rst_n = 1'b0;
        release_rst();
        apply(3'b000, 1'b0);
        chk("rise_pre", 32'(d_rise), 32'd0);
        apply(3'b011, 1'b0);
        chk("rise_dq", 32'(d_q), 32'd1);
        chk("rise_pulse", 32'(d_rise), 32'd1);
        apply(3'b011, 1'b0);
        chk("rise_end", 32'(d_rise), 32'd0);
        apply(3'b011, 1'b0);
        chk("rise_hold", 32'(d_rise), 32'd0);

        for (int i = 0; i < 300; i++) apply(3'b111, 1'b0);
        chk("sat_255", 32'(ones_cnt), 32'd255);
        apply(3'b111, 1'b0);
        chk("sat_stay", 32'(ones_cnt), 32'd255);

        apply(3'b001, 1'b0);
        apply(3'b110, 1'b0);
        #1 rst_n = 1'b0;
        #1;
        chk("midrst_dq", 32'(d_q), 32'd0);
        chk("midrst_seen", 32'(minterm_seen), 32'd0);
        chk("midrst_cnt", 32'(ones_cnt), 32'd0);
        chk("midrst_all", 32'(all_seen), 32'd0);
        chk("midrst_d", 32'(d), 32'd1);
        release_rst();
        apply(3'b111, 1'b0);
        apply(3'b010, 1'b0);
        chk("preclr_seen", 32'(minterm_seen), 32'h84);
        chk("preclr_cnt", 32'(ones_cnt), 32'd1);
        apply(3'b101, 1'b1);
        chk("clr_seen", 32'(minterm_seen), 32'd0);
        chk("clr_cnt", 32'(ones_cnt), 32'd0);
        chk("clr_dq", 32'(d_q), 32'd1);
        chk("clr_rise", 32'(d_rise), 32'd1);
        apply(3'b000, 1'b0);
        chk("postclr_seen", 32'(minterm_seen), 32'h01);
        chk("postclr_cnt", 32'(ones_cnt), 32'd1);
        @(negedge clk);
        #1;
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
